// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts rising edges of spike_in over a fixed window
// and measures the inter-spike interval between consecutive edges.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_CYCLES = 16,
  parameter int unsigned COUNT_W       = 8,
  parameter int unsigned ISI_W         = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               spike_in,
  output logic [COUNT_W-1:0] rate_count,
  output logic               rate_valid,
  output logic               rate_sat,
  output logic [ISI_W-1:0]   isi,
  output logic               isi_valid,
  output logic               isi_sat,
  output logic               busy
);

  localparam int unsigned WCNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic                 spike_d;
  logic                 rise;
  logic                 run_cycle;
  logic                 terminal;
  logic [WCNT_W-1:0]    wcnt;
  logic [COUNT_W-1:0]   acc;
  logic                 acc_sat;
  logic [COUNT_W:0]     acc_sum;
  logic [COUNT_W-1:0]   acc_next;
  logic                 acc_next_sat;
  logic [ISI_W-1:0]     isi_timer;
  logic                 timer_max;
  logic                 have_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // acc saturates in place, so overflow earlier in the window is remembered
  // in acc_sat; otherwise rate_sat would miss it at the terminal cycle.
  always_comb begin
    rise         = spike_in & ~spike_d;
    run_cycle    = (state == RUN) & enable;
    terminal     = (wcnt == WCNT_W'(WINDOW_CYCLES - 1));
    acc_sum      = {1'b0, acc} + (COUNT_W + 1)'(rise);
    acc_next     = acc_sum[COUNT_W] ? '1 : acc_sum[COUNT_W-1:0];
    acc_next_sat = acc_sat | acc_sum[COUNT_W];
    timer_max    = &isi_timer;
  end

  // Counters are held clear whenever not running, which covers the
  // clear-on-entry requirement and discards an aborted partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d    <= 1'b0;
      wcnt       <= '0;
      acc        <= '0;
      acc_sat    <= 1'b0;
      isi_timer  <= '0;
      have_prev  <= 1'b0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
      isi_sat    <= 1'b0;
    end else begin
      spike_d    <= spike_in;
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      if (!run_cycle) begin
        wcnt      <= '0;
        acc       <= '0;
        acc_sat   <= 1'b0;
        isi_timer <= '0;
        have_prev <= 1'b0;
      end else begin
        if (terminal) begin
          rate_count <= acc_next;
          rate_sat   <= acc_next_sat;
          rate_valid <= 1'b1;
          wcnt       <= '0;
          acc        <= '0;
          acc_sat    <= 1'b0;
        end else begin
          acc     <= acc_next;
          acc_sat <= acc_next_sat;
          wcnt    <= wcnt + WCNT_W'(1);
        end
        if (rise) begin
          if (have_prev) begin
            isi       <= timer_max ? '1 : isi_timer + ISI_W'(1);
            isi_sat   <= timer_max;
            isi_valid <= 1'b1;
          end
          isi_timer <= '0;
          have_prev <= 1'b1;
        end else if (!timer_max) begin
          isi_timer <= isi_timer + ISI_W'(1);
        end
      end
    end
  end

endmodule
